seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Downstream display stage for the lab 8 adder datapath.
- Accepts an 8-bit result on a load strobe and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes both digits onto one shared active-low seven-segment bus with per-digit anode enables.
- Replaces the per-digit static decoders, so the board needs one segment bus instead of two.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit is enabled before the scan switches digits. Legal range 2..2^20.
- BLANK_LEAD, 1: when 1, a tens digit of 0 is blanked. When 0, it shows '0'.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- value_in  input  8  unsigned result to display.
- load  input  1  one-cycle strobe; captures value_in.
- seg  output  7  {a,b,c,d,e,f,g}, active-low, registered.
- an  output  2  digit enables, active-low, registered. an[0] = ones, an[1] = tens.
- dp  output  1  decimal point, active-low, registered.
- busy  output  1  high while a conversion is running.

Behaviour:
- Reset, on the clk edge with rst=1:
  - Outputs: seg=7'b1111111, an=2'b11, dp=1, busy=0.
  - Internal state: display registers = blank code, scan counter = 0, digit select = ones, FSM = IDLE.
- First cycle after rst deasserts: an=2'b10, seg=blank (no load yet).
- FSM states are IDLE and CONV.
  - IDLE: when load=1 at an edge, latch value_in into the shift register, clear the BCD accumulator, set busy=1 and go to CONV.
  - CONV: runs exactly 8 cycles. Each cycle, first add 3 to any BCD nibble >=5, then shift left by one.
  - On the 8th CONV edge: update the display registers, set busy=0 and return to IDLE.
- Latency: load sampled at edge N. busy=1 after edges N..N+7. The new digits are visible on seg from edge N+8, at the next scan phase of each digit.
- load while busy: ignored; no queueing. The value in flight completes unchanged.
- load and rst together: rst wins.
- Reset mid-conversion: abort, display returns to blank.
- Digit encoding (seg value):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111, dash=1111110
- Overflow: value_in > 99 (hundreds nibble != 0):
  - Both digits show dash.
  - dp=0 while the tens digit is selected. Otherwise dp=1 always.
- Leading-zero blanking: tens = 0 and BLANK_LEAD=1 shows blank. Ones always shows a digit.
- Scan counter:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - On each wrap, the digit select toggles.
  - an, seg and dp update on the same edge as the toggle: an=2'b10 for ones, 2'b01 for tens. No cycle ever has both anodes low.
- The display registers update independently of the scan. The currently selected digit changes value mid-phase without a glitch, i.e. in one registered transition.

Optional Feature:
- Macro: DISP_HEX_EN.
- Defined:
  - The BCD engine is bypassed. value_in[3:0] drives ones and value_in[7:4] drives tens as hex glyphs: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - busy pulses for 1 cycle; the display updates on edge N+1.
  - No overflow and no blanking.
- Undefined: decimal behaviour as specified above.

Test Plan (SCAN_DIV=4, BLANK_LEAD=1, DISP_HEX_EN undefined unless noted):
- Reset, then hold 20 cycles, no load -> an alternates 10/01 every 4 cycles starting 10; seg=1111111; dp=1; busy=0.
- load with value_in=8'd27 -> busy high 8 cycles; afterwards ones phase seg=0001111 ('7') and tens phase seg=0010010 ('2').
- load 8'd5 -> tens phase blank 1111111, ones phase 0100100; repeat with BLANK_LEAD=0 -> tens 0000001.
- load 8'd150 -> both phases 1111110; dp=0 only while an=2'b01.
- load 8'd30, then load 8'd12 at the 3rd busy cycle -> second load ignored; display shows '3','0'; reset asserted mid-conversion of a fresh load -> blank display, busy=0 next cycle.
- DISP_HEX_EN defined, load 8'hAF -> busy 1 cycle; tens=0001000, ones=0111000.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// Result-in / segment-bus-out signal bundle for seg_scan_driver.
// The master side supplies the value and strobe; the slave side drives the display.
interface seg_scan_driver_if;
  logic [7:0] value_in;
  logic       load;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;
  logic       busy;

  modport master (
    output value_in, load,
    input  seg, an, dp, busy
  );

  modport slave (
    input  value_in, load,
    output seg, an, dp, busy
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver with a sequential binary-to-BCD engine.
// Optional build macro DISP_HEX_EN replaces the decimal conversion with a direct hex display.
module seg_scan_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_LEAD = 1
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_driver_if.slave  bus
);

  typedef enum logic {IDLE, CONV} state_e;

  localparam int                CNT_W       = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  SCAN_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]        GLYPH_BLANK = 7'b1111111;
`ifndef DISP_HEX_EN
  localparam logic [6:0]        GLYPH_DASH  = 7'b1111110;
  localparam logic [2:0]        CONV_LAST   = 3'd7;
`else
  localparam logic [2:0]        CONV_LAST   = 3'd0;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       ones_q, ones_d;
  logic [6:0]       tens_q, tens_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] scan_q, scan_d;
  logic             sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             dp_q, dp_d;
  logic             wrap;

`ifndef DISP_HEX_EN
  // BCD accumulator: hundreds (2 bits, max 2), tens, ones.
  logic [9:0] bcd_q, bcd_d;
  logic [7:0] bcd_adj;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                              : bcd_q[gi*4 +: 4];
    end
  endgenerate
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    ovf_d     = ovf_q;
`ifndef DISP_HEX_EN
    bcd_d     = bcd_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          shift_d   = bus.value_in;
          bit_cnt_d = '0;
`ifndef DISP_HEX_EN
          bcd_d     = '0;
`endif
          state_d   = CONV;
        end
      end
      default: begin
`ifndef DISP_HEX_EN
        bcd_d   = {bcd_q[8], bcd_adj, shift_q[7]};
        shift_d = {shift_q[6:0], 1'b0};
`endif
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == CONV_LAST) begin
          state_d = IDLE;
`ifndef DISP_HEX_EN
          if (bcd_d[9:8] != 2'd0) begin
            ones_d = GLYPH_DASH;
            tens_d = GLYPH_DASH;
            ovf_d  = 1'b1;
          end else begin
            ones_d = glyph(bcd_d[3:0]);
            tens_d = (BLANK_LEAD != 0 && bcd_d[7:4] == 4'd0) ? GLYPH_BLANK : glyph(bcd_d[7:4]);
            ovf_d  = 1'b0;
          end
`else
          ones_d = glyph(shift_q[3:0]);
          tens_d = glyph(shift_q[7:4]);
          ovf_d  = 1'b0;
`endif
        end
      end
    endcase
  end

  // Outputs follow next-state select and display so a value change or a digit
  // toggle lands in a single registered transition.
  always_comb begin
    wrap   = (scan_q == SCAN_LAST);
    scan_d = wrap ? '0 : scan_q + CNT_W'(1);
    sel_d  = wrap ? ~sel_q : sel_q;
    seg_d  = sel_d ? tens_d : ones_d;
    an_d   = sel_d ? 2'b01 : 2'b10;
    dp_d   = ~(ovf_d & sel_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ones_q    <= GLYPH_BLANK;
      tens_q    <= GLYPH_BLANK;
      ovf_q     <= 1'b0;
      scan_q    <= '0;
      sel_q     <= 1'b0;
      seg_q     <= GLYPH_BLANK;
      an_q      <= 2'b11;
      dp_q      <= 1'b1;
`ifndef DISP_HEX_EN
      bcd_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      ovf_q     <= ovf_d;
      scan_q    <= scan_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
`ifndef DISP_HEX_EN
      bcd_q     <= bcd_d;
`endif
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.dp   = dp_q;
  assign bus.busy = (state_q == CONV);

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: two instances (leading-zero blanking on/off)
// driven with directed and random loads, checked every cycle against an arithmetic model.
module tb_seg_scan_driver;

  localparam int SCAN_DIV = 4;
`ifdef DISP_HEX_EN
  localparam int CONV_CYC = 1;
`else
  localparam int CONV_CYC = 8;
`endif

  typedef struct packed {
    logic [6:0] ones;
    logic [6:0] tens1;
    logic [6:0] tens0;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   sbusy  = 0;
  exp_t sb_q[$];

  logic [6:0] gly [16];
  logic [6:0] blank_g;
  logic [6:0] dash_g;

  seg_scan_driver_if bus1 ();
  seg_scan_driver_if bus0 ();

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_LEAD(1)) dut  (.clk(clk), .rst(rst), .bus(bus1));
  seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_LEAD(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input int v);
    exp_t e;
`ifdef DISP_HEX_EN
    e.ones  = gly[v % 16];
    e.tens1 = gly[v / 16];
    e.tens0 = gly[v / 16];
    e.ovf   = 1'b0;
`else
    if (v > 99) begin
      e.ones  = dash_g;
      e.tens1 = dash_g;
      e.tens0 = dash_g;
      e.ovf   = 1'b1;
    end else begin
      e.ones  = gly[v % 10];
      e.tens0 = gly[v / 10];
      e.tens1 = (v / 10 == 0) ? blank_g : gly[v / 10];
      e.ovf   = 1'b0;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, expv);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [7:0] v);
    @(negedge clk);
    rst = r;
    bus1.load = l; bus0.load = l;
    bus1.value_in = v; bus0.value_in = v;
    if (r) sbusy = 0;
    else if (sbusy > 0) sbusy--;
    else if (l) begin
      sb_q.push_back(model(int'(v)));
      sbusy = CONV_CYC;
      $display("load value=%0d t=%0t", v, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'd0);
  endtask

  // Monitor: tracks scan position and busy window, pops the scoreboard when busy falls.
  initial begin
    exp_t cur;
    int   k;
    int   mb;
    logic pb;
    logic rs;
    logic ld;
    logic sel;
    k = 0; mb = 0; pb = 1'b0;
    cur = '{ones: 7'h7F, tens1: 7'h7F, tens0: 7'h7F, ovf: 1'b0};
    forever begin
      @(posedge clk);
      rs = rst;
      ld = bus1.load;
      if (rs) begin
        k = 0; mb = 0;
        sb_q.delete();
        cur = '{ones: blank_g, tens1: blank_g, tens0: blank_g, ovf: 1'b0};
      end else begin
        k++;
        if (mb > 0) mb--;
        else if (ld) mb = CONV_CYC;
      end
      @(negedge clk);
      if (!rs && pb && !bus1.busy) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_pop t=%0t got=busy_fall exp=no_pending_result", $time);
        end else begin
          cur = sb_q.pop_front();
          $display("result ones=%b tens=%b ovf=%0b t=%0t", cur.ones, cur.tens1, cur.ovf, $time);
        end
      end
      pb = bus1.busy;
      if (rs) begin
        chk("rst_seg",  bus1.seg,  7'h7F);
        chk("rst_an",   bus1.an,   2'b11);
        chk("rst_dp",   bus1.dp,   1'b1);
        chk("rst_busy", bus1.busy, 1'b0);
        chk("rst_seg0", bus0.seg,  7'h7F);
        chk("rst_an0",  bus0.an,   2'b11);
      end else begin
        sel = ((k / SCAN_DIV) % 2) == 1;
        chk("an",    bus1.an,   sel ? 2'b01 : 2'b10);
        chk("an0",   bus0.an,   sel ? 2'b01 : 2'b10);
        chk("seg",   bus1.seg,  sel ? cur.tens1 : cur.ones);
        chk("seg0",  bus0.seg,  sel ? cur.tens0 : cur.ones);
        chk("dp",    bus1.dp,   (cur.ovf && sel) ? 1'b0 : 1'b1);
        chk("busy",  bus1.busy, mb > 0);
        chk("busy0", bus0.busy, mb > 0);
      end
    end
  end

  initial begin
    logic       r;
    logic       l;
    logic [7:0] v;
    gly = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
            7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    blank_g = 7'b1111111;
    dash_g  = 7'b1111110;
    rst = 1'b1;
    bus1.load = 1'b0; bus0.load = 1'b0;
    bus1.value_in = 8'd0; bus0.value_in = 8'd0;

    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    idle(20);
    step(1'b0, 1'b1, 8'd27);  idle(14);
    step(1'b0, 1'b1, 8'd5);   idle(14);
    step(1'b0, 1'b1, 8'd150); idle(14);
    // Second load lands on the third busy cycle and must be ignored.
    step(1'b0, 1'b1, 8'd30);
    idle(2);
    step(1'b0, 1'b1, 8'd12);
    idle(14);
    // Reset in the middle of a fresh conversion.
    step(1'b0, 1'b1, 8'd77);
    idle(3);
    step(1'b1, 1'b0, 8'd0);
    idle(10);
    // Load coincident with reset: reset wins.
    step(1'b0, 1'b1, 8'd64); idle(12);
    step(1'b1, 1'b1, 8'd55); idle(10);
    foreach (gly[i]) begin
      step(1'b0, 1'b1, (i == 0) ? 8'd99 : (i == 1) ? 8'd100 : (i == 2) ? 8'd0 :
                       (i == 3) ? 8'd10 : (i == 4) ? 8'd255 : 8'(i * 16 + i));
      idle(10);
    end
    repeat (400) begin
      r = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 3) == 0);
      v = 8'($urandom_range(0, 255));
      step(r, l, v);
    end
    idle(20);
    @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
